uart_rx_os16: RTL and testbench

- Receive-side neighbour of the 16x-oversampled UART transmitter; consumes the serial line that transmitter drives (board loopback or external TXD).
- Recovers 8N1 frames using the same shared 16x baud tick and delivers each byte on a one-clock valid strobe.
- Flags framing errors.
- Runs entirely in the system clock domain, clocked on `clk`.

---
 rtl/uart_rx_os16.sv | 153 +++++++++++++++
 tb/tb_uart_rx_os16.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver sampling on a shared 16x baud tick; delivers each byte on a one-clk valid strobe.
// Optional UART_RX_MAJORITY_EN: each bit decision is a 2-of-3 vote over three consecutive ticks.
module uart_rx_os16 #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clk_rx,
    input  logic                 i_rxd,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [3:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   armed_q, armed_d;
    logic                   rxd_s;
    logic                   rxd_dec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_rxd};
        end
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    // The two older votes are held here; the third is the live rxd_s at the decision tick.
    logic [1:0] samp_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp_q <= 2'b11;
        end else if (i_clk_rx) begin
            samp_q <= {samp_q[0], rxd_s};
        end
    end

    assign rxd_dec = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxd_s) | (samp_q[0] & rxd_s);
`else
    assign rxd_dec = rxd_s;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        armed_d = armed_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Arming on a high tick keeps a line stuck low from retriggering.
                if (i_clk_rx && rxd_s) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !rxd_s) begin
                    state_d = START;
                    cnt_d   = 4'd0;
                    armed_d = 1'b0;
                end
            end
            START: begin
                if (i_clk_rx) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = 4'd0;
                        idx_d   = '0;
                        state_d = rxd_dec ? IDLE : DATA;
                    end
                end
            end
            DATA: begin
                if (i_clk_rx) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        shreg_d = {rxd_dec, shreg_q[DATA_BITS-1:1]};
                        if (idx_q == LAST_IDX) begin
                            state_d = STOP;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            STOP: begin
                if (i_clk_rx) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = IDLE;
                        if (rxd_dec) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: 8N1 frames at 16 ticks/bit with a tick every 4 clks.
module tb_uart_rx_os16;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i_clk_rx;
    logic       i_rxd = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;
    logic [1:0] tdiv = 2'd0;

    int         n_tests = 0;
    int         n_fail = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         bad_overlap = 0;
    int         bad_busy = 0;
    int         v0, f0;
    logic [7:0] rxq[$];
    logic [7:0] exp_b2b[3];
    logic [7:0] part;

    uart_rx_os16 #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_clk_rx   (i_clk_rx),
        .i_rxd      (i_rxd),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tdiv <= tdiv + 2'd1;
    assign i_clk_rx = (tdiv == 2'd3);

    always @(negedge clk) begin
        if (o_valid) begin
            n_valid++;
            rxq.push_back(o_data);
            if (o_busy) bad_busy++;
        end
        if (o_frame_err) n_ferr++;
        if (o_valid && o_frame_err) bad_overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Optional glitch inverts the line for 4 clks (one tick) in the middle of the bit.
    task automatic drive_bit(input logic b, input bit glitch);
        for (int c = 0; c < BIT_CLKS; c++) begin
            i_rxd = b ^ (glitch && c >= 28 && c < 32);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gbit);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], i == gbit);
        drive_bit(stop, 1'b0);
    endtask

    task automatic idle_bits(input int nbits);
        i_rxd = 1'b1;
        repeat (nbits * BIT_CLKS) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check("rst_data", o_data, 8'h00);
        check("rst_valid", o_valid, 1'b0);
        check("rst_ferr", o_frame_err, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        reset = 1'b1;
        idle_bits(2);

        v0 = n_valid; f0 = n_ferr;
        send_frame(8'hA5, 1'b1, -1);
        idle_bits(1);
        check("a5_valid_cnt", n_valid - v0, 1);
        check("a5_data", o_data, 8'hA5);
        check("a5_ferr_cnt", n_ferr - f0, 0);
        check("a5_busy_idle", o_busy, 1'b0);

        v0 = n_valid; f0 = n_ferr;
        i_rxd = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("glitch_busy", o_busy, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        idle_bits(2);
        check("glitch_valid_cnt", n_valid - v0, 0);
        check("glitch_ferr_cnt", n_ferr - f0, 0);
        check("glitch_idle", o_busy, 1'b0);

        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, -1);
        idle_bits(1);
        check("ferr_cnt", n_ferr - f0, 1);
        check("ferr_valid_cnt", n_valid - v0, 0);
        check("ferr_data_held", o_data, 8'hA5);
        v0 = n_valid;
        send_frame(8'h81, 1'b1, -1);
        idle_bits(1);
        check("after_ferr_valid", n_valid - v0, 1);
        check("after_ferr_data", o_data, 8'h81);

        rxq.delete();
        exp_b2b[0] = 8'h00; exp_b2b[1] = 8'hFF; exp_b2b[2] = 8'h55;
        for (int i = 0; i < 3; i++) send_frame(exp_b2b[i], 1'b1, -1);
        idle_bits(1);
        check("b2b_count", rxq.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b_byte%0d", i), (i < rxq.size()) ? rxq[i] : 8'hxx, exp_b2b[i]);

        reset = 1'b0;
        i_rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        v0 = n_valid; f0 = n_ferr;
        repeat (30 * BIT_CLKS) @(posedge clk);
        #1;
        check("low_ferr_atmost1", (n_ferr - f0) <= 1, 1'b1);
        check("low_valid_cnt", n_valid - v0, 0);
        check("low_busy", o_busy, 1'b0);
        idle_bits(2);
        send_frame(8'h12, 1'b1, -1);
        idle_bits(1);
        check("low_then_valid", n_valid - v0, 1);
        check("low_then_data", o_data, 8'h12);

        v0 = n_valid; f0 = n_ferr;
        part = 8'h77;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(part[i], 1'b0);
        check("mid_busy", o_busy, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", o_busy, 1'b0);
        check("mid_rst_data", o_data, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        idle_bits(2);
        send_frame(8'h5A, 1'b1, -1);
        idle_bits(1);
        check("mid_valid_cnt", n_valid - v0, 1);
        check("mid_ferr_cnt", n_ferr - f0, 0);
        check("mid_data", o_data, 8'h5A);

`ifdef UART_RX_MAJORITY_EN
        v0 = n_valid;
        send_frame(8'hC6, 1'b1, 3);
        idle_bits(1);
        check("maj_valid_cnt", n_valid - v0, 1);
        check("maj_data", o_data, 8'hC6);
`endif

        check("valid_ferr_overlap", bad_overlap, 0);
        check("busy_low_at_valid", bad_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
